// File: rtl/scan_ctrl_pkg.sv
// Shared types and helpers for the scan chain controller.
//   scan_state_e : controller FSM encoding
//   cnt_width()  : width of a counter that must hold 0..chain_len
package scan_ctrl_pkg;

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StShiftIn  = 3'd1,
        StCapture  = 3'd2,
        StShiftOut = 3'd3,
        StDone     = 3'd4
    } scan_state_e;

    function automatic int unsigned cnt_width(input int unsigned chain_len);
        return $clog2(chain_len + 1);
    endfunction

endpackage

// File: rtl/scan_chain_ctrl_if.sv
// Host-side handshake of the scan chain controller.
//   start    : request one scan test (host -> ctrl)
//   pattern  : stimulus, bit k ends up in cell k (host -> ctrl)
//   expected : expected captured value, bit k = cell k (host -> ctrl)
//   busy     : test in progress (ctrl -> host)
//   done     : one-cycle result strobe (ctrl -> host)
//   resp     : captured response (ctrl -> host)
//   err_mask : resp ^ expected (ctrl -> host)
//   pass     : err_mask == 0 (ctrl -> host)
interface scan_chain_ctrl_if #(
    parameter int unsigned CHAIN_LEN = 8
);
    logic                 start;
    logic [CHAIN_LEN-1:0] pattern;
    logic [CHAIN_LEN-1:0] expected;
    logic                 busy;
    logic                 done;
    logic [CHAIN_LEN-1:0] resp;
    logic [CHAIN_LEN-1:0] err_mask;
    logic                 pass;

    modport master (
        output start, pattern, expected,
        input  busy, done, resp, err_mask, pass
    );

    modport slave (
        input  start, pattern, expected,
        output busy, done, resp, err_mask, pass
    );
endinterface

// File: rtl/scan_bit_cnt.sv
// Loadable down-counter with zero flag; indexes chain bits while shifting.
//   clk_i, rst_ni : clock, async active-low reset
//   load_i        : load load_val_i (has priority over dec_i)
//   load_val_i    : value to load
//   dec_i         : decrement by one
//   cnt_o         : current count
//   zero_o        : cnt_o == 0
module scan_bit_cnt #(
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             zero_o
);
    logic [CNT_W-1:0] cnt_d, cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign zero_o = (cnt_q == '0);
endmodule

// File: rtl/scan_chain_ctrl.sv
// Sequencer for one serial scan chain: shift in a pattern, capture once,
// shift the response out and compare it against an expected vector.
//   CLK, RSTn : chain clock, async active-low reset
//   host      : start/pattern/expected in, busy/done/resp/err_mask/pass out
//   SE, SI    : scan enable and serial input driven into the chain
//   SO        : serial output of the last chain cell
// All outputs come straight from flops.
module scan_chain_ctrl
    import scan_ctrl_pkg::*;
#(
    parameter int unsigned CHAIN_LEN = 8
) (
    input  logic                CLK,
    input  logic                RSTn,
    scan_chain_ctrl_if.slave    host,
    output logic                SE,
    output logic                SI,
    input  logic                SO
);
    localparam int unsigned          CNT_W = cnt_width(CHAIN_LEN);
    localparam logic [CNT_W-1:0]     LastIdx = CNT_W'(CHAIN_LEN - 1);
    localparam logic [CHAIN_LEN-1:0] OneLsb  = CHAIN_LEN'(1);

    scan_state_e state_d, state_q;

    logic [CHAIN_LEN-1:0] pat_d, pat_q;
    logic [CHAIN_LEN-1:0] exp_d, exp_q;
    logic [CHAIN_LEN-1:0] cap_d, cap_q;
    logic [CHAIN_LEN-1:0] resp_d, resp_q;
    logic [CHAIN_LEN-1:0] err_d, err_q;
    logic                 pass_d, pass_q;
    logic                 se_d, se_q;
    logic                 si_d, si_q;
    logic                 busy_d, busy_q;
    logic                 done_d, done_q;

    logic                 cnt_load, cnt_dec, cnt_zero;
    logic [CNT_W-1:0]     cnt, cnt_m1;
    logic [CHAIN_LEN-1:0] pat_next_bit;
    logic [CHAIN_LEN-1:0] bit_sel;

    scan_bit_cnt #(
        .CNT_W (CNT_W)
    ) u_bit_cnt (
        .clk_i      (CLK),
        .rst_ni     (RSTn),
        .load_i     (cnt_load),
        .load_val_i (LastIdx),
        .dec_i      (cnt_dec),
        .cnt_o      (cnt),
        .zero_o     (cnt_zero)
    );

    // SI is registered, so it is set up one cycle ahead using the
    // post-decrement index.
    assign cnt_m1       = cnt - CNT_W'(1);
    assign pat_next_bit = pat_q >> cnt_m1;
    assign bit_sel      = OneLsb << cnt;

    always_comb begin
        state_d  = state_q;
        pat_d    = pat_q;
        exp_d    = exp_q;
        cap_d    = cap_q;
        resp_d   = resp_q;
        err_d    = err_q;
        pass_d   = pass_q;
        se_d     = 1'b0;
        si_d     = 1'b0;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (host.start) begin
                    state_d  = StShiftIn;
                    pat_d    = host.pattern;
                    exp_d    = host.expected;
                    cnt_load = 1'b1;
                    se_d     = 1'b1;
                    si_d     = host.pattern[CHAIN_LEN-1];
                    busy_d   = 1'b1;
                end
            end
            StShiftIn: begin
                busy_d = 1'b1;
                if (cnt_zero) begin
                    state_d = StCapture;
                end else begin
                    cnt_dec = 1'b1;
                    se_d    = 1'b1;
                    si_d    = pat_next_bit[0];
                end
            end
            StCapture: begin
                state_d  = StShiftOut;
                cnt_load = 1'b1;
                se_d     = 1'b1;
                busy_d   = 1'b1;
            end
            StShiftOut: begin
                cap_d = SO ? (cap_q | bit_sel) : (cap_q & ~bit_sel);
                if (cnt_zero) begin
                    state_d = StDone;
                    resp_d  = cap_d;
                    err_d   = cap_d ^ exp_q;
                    pass_d  = (err_d == '0);
                    done_d  = 1'b1;
                end else begin
                    cnt_dec = 1'b1;
                    se_d    = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            StDone: begin
                // start during DONE is deliberately not looked at
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q <= StIdle;
            pat_q   <= '0;
            exp_q   <= '0;
            cap_q   <= '0;
            resp_q  <= '0;
            err_q   <= '0;
            pass_q  <= 1'b0;
            se_q    <= 1'b0;
            si_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            exp_q   <= exp_d;
            cap_q   <= cap_d;
            resp_q  <= resp_d;
            err_q   <= err_d;
            pass_q  <= pass_d;
            se_q    <= se_d;
            si_q    <= si_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign SE            = se_q;
    assign SI            = si_q;
    assign host.busy     = busy_q;
    assign host.done     = done_q;
    assign host.resp     = resp_q;
    assign host.err_mask = err_q;
    assign host.pass     = pass_q;
endmodule

// File: tb/tb_scan_chain_ctrl.sv
module tb_scan_chain_ctrl;
    localparam int unsigned N = 4;

    logic         CLK  = 1'b0;
    logic         RSTn = 1'b1;
    logic         SE, SI, SO;
    logic [N-1:0] chain;
    logic [N-1:0] di;

    scan_chain_ctrl_if #(.CHAIN_LEN(N)) host ();

    scan_chain_ctrl #(
        .CHAIN_LEN (N)
    ) dut (
        .CLK  (CLK),
        .RSTn (RSTn),
        .host (host),
        .SE   (SE),
        .SI   (SI),
        .SO   (SO)
    );

    always #5 CLK = ~CLK;

    // Chain of N SDFFs: cell 0 next to SI, cell N-1 drives SO.
    always @(posedge CLK) chain <= SE ? {chain[N-2:0], SI} : di;
    assign SO = chain[N-1];

    typedef struct packed {
        logic [N-1:0] resp;
        logic [N-1:0] err;
        logic         pass;
    } res_t;

    res_t sb[$];
    int   n_tests  = 0;
    int   n_fail   = 0;
    int   done_cnt = 0;

    function automatic res_t model(input logic [N-1:0] d, input logic [N-1:0] x);
        res_t r;
        r.resp = d;
        r.err  = d ^ x;
        r.pass = (d == x);
        return r;
    endfunction

    // Scoreboard: each done pops the result expected for that test.
    always @(negedge CLK) begin : mon
        res_t e;
        if (RSTn && host.done) begin
            done_cnt++;
            n_tests++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_done: done pulsed with no test outstanding");
            end else begin
                e = sb.pop_front();
                if (host.resp !== e.resp) begin
                    n_fail++;
                    $display("FAIL resp: got %b want %b", host.resp, e.resp);
                end
                n_tests++;
                if (host.err_mask !== e.err) begin
                    n_fail++;
                    $display("FAIL err_mask: got %b want %b", host.err_mask, e.err);
                end
                n_tests++;
                if (host.pass !== e.pass) begin
                    n_fail++;
                    $display("FAIL pass: got %b want %b", host.pass, e.pass);
                end
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Runs one test from IDLE and records what it sees; no checking here.
    task automatic run_one(input logic [N-1:0] pat, input logic [N-1:0] x,
                           input logic [N-1:0] d, output int done_cyc,
                           output logic [N-1:0] si_seq, output int se_low,
                           output logic [N-1:0] chain_at_done);
        host.pattern  = pat;
        host.expected = x;
        di            = d;
        sb.push_back(model(d, x));
        host.start = 1'b1;
        tick();
        host.start    = 1'b0;
        done_cyc      = -1;
        se_low        = 0;
        si_seq        = '0;
        chain_at_done = 'x;
        for (int c = 1; c <= 2 * N + 4; c++) begin
            if (c <= N) si_seq[N-c] = SI;
            if (c <= 2 * N + 1 && SE == 1'b0) se_low++;
            if (host.done === 1'b1 && done_cyc < 0) begin
                done_cyc      = c;
                chain_at_done = chain;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        host.start    = 1'b0;
        host.pattern  = '0;
        host.expected = '0;
        di            = '0;
        #2 RSTn = 1'b0;
        repeat (2) tick();
        n_tests++;
        if ({SE, SI, host.busy, host.done, host.resp, host.err_mask, host.pass} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: SE=%b SI=%b busy=%b done=%b resp=%b err=%b pass=%b want all 0",
                     SE, SI, host.busy, host.done, host.resp, host.err_mask, host.pass);
        end
        RSTn = 1'b1;
        repeat (2) tick();
    endtask

    task automatic test_basic();
        int dc, sl;
        logic [N-1:0] sis, ch;
        run_one(4'b0110, 4'b1010, 4'b1010, dc, sis, sl, ch);
        n_tests++;
        if (sis !== 4'b0110) begin
            n_fail++;
            $display("FAIL basic_si_order: got %b want %b", sis, 4'b0110);
        end
        n_tests++;
        if (sl != 1) begin
            n_fail++;
            $display("FAIL basic_se_low_cycles: got %0d want 1", sl);
        end
        n_tests++;
        if (dc != 2 * N + 2) begin
            n_fail++;
            $display("FAIL basic_latency: got %0d want %0d", dc, 2 * N + 2);
        end
        n_tests++;
        if (ch !== '0) begin
            n_fail++;
            $display("FAIL basic_flush: chain %b want 0000", ch);
        end
        n_tests++;
        if ({host.resp, host.pass, host.busy} !== {4'b1010, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL basic_hold: resp=%b pass=%b busy=%b want 1010 1 0",
                     host.resp, host.pass, host.busy);
        end
    endtask

    task automatic test_mismatch();
        int dc, sl;
        logic [N-1:0] sis, ch;
        run_one(4'b1100, 4'b1011, 4'b1010, dc, sis, sl, ch);
        n_tests++;
        if (dc != 2 * N + 2) begin
            n_fail++;
            $display("FAIL mismatch_latency: got %0d want %0d", dc, 2 * N + 2);
        end
        n_tests++;
        if (sis !== 4'b1100) begin
            n_fail++;
            $display("FAIL mismatch_si_order: got %b want 1100", sis);
        end
    endtask

    task automatic test_shift_in();
        int w;
        int d0;
        d0            = done_cnt;
        host.pattern  = 4'b1001;
        host.expected = 4'b0011;
        sb.push_back(model(4'b0011, 4'b0011));
        host.start = 1'b1;
        tick();
        host.start = 1'b0;
        di         = 'x;
        repeat (N) tick();
        n_tests++;
        if (chain !== 4'b1001) begin
            n_fail++;
            $display("FAIL shift_in_contents: chain %b want 1001", chain);
        end
        n_tests++;
        if (SE !== 1'b0) begin
            n_fail++;
            $display("FAIL shift_in_capture_se: SE %b want 0", SE);
        end
        di = 4'b0011;
        w  = 0;
        while (done_cnt == d0 && w < 2 * N + 4) begin
            tick();
            w++;
        end
        n_tests++;
        if (done_cnt != d0 + 1) begin
            n_fail++;
            $display("FAIL shift_in_done_timeout: done count %0d want %0d", done_cnt, d0 + 1);
        end
        repeat (2) tick();
    endtask

    task automatic test_start_busy();
        int d0;
        int w;
        d0            = done_cnt;
        host.pattern  = 4'b0101;
        host.expected = 4'b1100;
        di            = 4'b1100;
        sb.push_back(model(4'b1100, 4'b1100));
        host.start = 1'b1;
        tick();
        host.start = 1'b0;
        repeat (6) tick();
        // cycle 7: SHIFT_OUT; a competing request must be ignored
        host.start    = 1'b1;
        host.pattern  = 4'b1111;
        host.expected = 4'b0000;
        tick();
        host.start = 1'b0;
        repeat (2) tick();
        n_tests++;
        if (host.done !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_start_done: done %b want 1 at cycle %0d", host.done, 2 * N + 2);
        end
        tick();
        host.start    = 1'b1;
        host.pattern  = 4'b0011;
        host.expected = 4'b0011;
        di            = 4'b0110;
        sb.push_back(model(4'b0110, 4'b0011));
        tick();
        host.start = 1'b0;
        n_tests++;
        if (host.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_restart_accept: busy %b want 1", host.busy);
        end
        w = 0;
        while (done_cnt < d0 + 2 && w < 2 * N + 4) begin
            tick();
            w++;
        end
        repeat (4) tick();
        n_tests++;
        if (done_cnt != d0 + 2) begin
            n_fail++;
            $display("FAIL busy_done_count: got %0d want %0d", done_cnt - d0, 2);
        end
    endtask

    task automatic test_reset_mid();
        int d0;
        int dc, sl;
        logic [N-1:0] sis, ch;
        host.pattern  = 4'b1110;
        host.expected = 4'b0001;
        di            = 4'b0001;
        sb.push_back(model(4'b0001, 4'b0001));
        host.start = 1'b1;
        tick();
        host.start = 1'b0;
        repeat (6) tick();
        // cycle 7: second unload cycle
        RSTn = 1'b0;
        #1;
        n_tests++;
        if ({SE, host.busy, host.done, host.resp, host.err_mask, host.pass} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_outputs: SE=%b busy=%b done=%b resp=%b err=%b pass=%b want all 0",
                     SE, host.busy, host.done, host.resp, host.err_mask, host.pass);
        end
        sb.delete();
        @(posedge CLK);
        #1;
        RSTn = 1'b1;
        d0   = done_cnt;
        repeat (2 * N + 4) tick();
        n_tests++;
        if (done_cnt != d0 || host.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_no_done: dones %0d busy %b want 0 0", done_cnt - d0, host.busy);
        end
        run_one(4'b1011, 4'b1001, 4'b1001, dc, sis, sl, ch);
        n_tests++;
        if (dc != 2 * N + 2) begin
            n_fail++;
            $display("FAIL reset_mid_recover: latency %0d want %0d", dc, 2 * N + 2);
        end
    endtask

    task automatic test_back_to_back();
        logic [N-1:0] dis [4];
        logic [N-1:0] exs [4];
        int w;
        dis = '{4'b1010, 4'b0111, 4'b1111, 4'b0000};
        exs = '{4'b1010, 4'b0101, 4'b1111, 4'b1000};
        host.pattern  = 4'b0110;
        host.expected = exs[0];
        host.start    = 1'b1;
        for (int k = 0; k < 4; k++) begin
            sb.push_back(model(dis[k], exs[k]));
            w = 0;
            while (host.busy !== 1'b1 && w < 4) begin
                tick();
                w++;
            end
            n_tests++;
            if (host.busy !== 1'b1) begin
                n_fail++;
                $display("FAIL b2b_accept_timeout: test %0d never became busy", k);
            end
            di = dis[k];
            if (k < 3) host.expected = exs[k+1];
            else       host.start    = 1'b0;
            w = 0;
            while (host.done !== 1'b1 && w < 2 * N + 4) begin
                tick();
                w++;
            end
            n_tests++;
            if (host.done !== 1'b1) begin
                n_fail++;
                $display("FAIL b2b_done_timeout: test %0d got no done", k);
            end
            tick();
            n_tests++;
            if (host.busy !== 1'b0) begin
                n_fail++;
                $display("FAIL b2b_idle_gap: test %0d busy %b want 0", k, host.busy);
            end
            tick();
            n_tests++;
            if (host.busy !== (k < 3)) begin
                n_fail++;
                $display("FAIL b2b_next_busy: test %0d busy %b want %b", k, host.busy, k < 3);
            end
        end
        repeat (2) tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_mismatch();
        test_shift_in();
        test_start_busy();
        test_reset_mid();
        test_back_to_back();
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL sb_leftover: %0d results never reported", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/scan_chain_ctrl.md
Name: scan_chain_ctrl

Overview:
- Sequencer for one serial scan chain of SDFF cells that share SE and are linked SI→SO.
- Runs one full scan test per request:
  - shifts a parallel stimulus pattern into the chain (SE=1),
  - applies one functional capture cycle (SE=0, the chain loads DI),
  - shifts the captured response out through SO,
  - compares the response against an expected vector and reports pass/fail plus a per-bit error mask.
- Sits between the test host or bench and the chain. It is the only driver of the chain's SE and SI.

Parameters:
- CHAIN_LEN, 8, number of SDFF cells in the chain (N). Legal range 2..256.
- CNT_W, $clog2(CHAIN_LEN+1), width of the bit counter. Derived; never overridden.

Ports:
- CLK  in  1  Chain clock. The controller and all SDFFs are posedge on the same CLK.
- RSTn  in  1  Asynchronous, active-low reset.
- start  in  1  Request a scan test. Sampled only in IDLE.
- pattern  in  N  Stimulus. Cell k (k=0 nearest SI) must hold pattern[k] at capture.
- expected  in  N  Expected captured value; bit k corresponds to cell k.
- SE  out  1  Scan enable to all chain cells.
- SI  out  1  Serial data into cell 0.
- SO  in  1  Serial out of cell N-1.
- busy  out  1  High from the cycle after start is accepted until done.
- done  out  1  One-cycle pulse; resp, err_mask and pass are valid from this cycle.
- resp  out  N  Captured response; bit k is the value of cell k.
- err_mask  out  N  resp XOR expected.
- pass  out  1  err_mask == 0.

Behaviour:
- Reset (async, RSTn=0):
  - state=IDLE, SE=0 (functional mode), SI=0, busy=0, done=0, resp=0, err_mask=0, pass=0, counter=0.
  - Takes effect immediately, mid-operation included; no partial result is reported.
- All outputs are registered; no combinational path from any input to any output.
- IDLE:
  - SE=0, busy=0.
  - If start=1 at a posedge: latch pattern and expected, load counter=N-1, go to SHIFT_IN.
- SHIFT_IN (N cycles):
  - SE=1.
  - SI = latched pattern[counter], so pattern[N-1] goes first and pattern[0] last.
  - Counter decrements each cycle; when it reaches 0, go to CAPTURE.
- CAPTURE (1 cycle):
  - SE=0, SI=0. The chain loads DI on the closing edge.
  - Load counter=N-1, go to SHIFT_OUT.
- SHIFT_OUT (N cycles):
  - SE=1, SI=0.
  - On each posedge, sample SO into resp[counter], so the first sample is cell N-1 and the last is cell 0.
  - Counter decrements; after the sample at counter 0, compute err_mask and pass and go to DONE.
- DONE (1 cycle):
  - done=1, busy=0, SE=0. Return to IDLE.
  - A start that is high during DONE is ignored; it must be held into IDLE.
- Latency: start-accept edge to done is 2N+2 cycles.
- SE profile per test: N cycles at 1, 1 cycle at 0, N cycles at 1.
- start while busy is ignored. pattern and expected changes after acceptance have no effect.
- resp, err_mask and pass hold their value until the next DONE or reset.
- After a test the chain holds all zeros (flushed by SI=0).

Decomposition:
- Package scan_ctrl_pkg holds:
  - state encoding: IDLE=3'd0, SHIFT_IN=3'd1, CAPTURE=3'd2, SHIFT_OUT=3'd3, DONE=3'd4;
  - the CNT_W derivation function.
- One natural sub-module: scan_bit_cnt, a loadable down-counter with a zero flag, instantiated once and shared by SHIFT_IN and SHIFT_OUT.
- FSM, pattern/expected latches and response register stay in scan_chain_ctrl.

Test Plan (CHAIN_LEN=4, chain of 4 SDFFs, DI bus driven by the bench):
- Basic pass: DI=4'b1010, pattern=4'b0110, expected=4'b1010, start for 1 cycle → SI during SHIFT_IN = 0,1,1,0; exactly one SE=0 cycle; done 10 cycles after accept; resp=1010, err_mask=0000, pass=1.
- Mismatch: DI=4'b1010, expected=4'b1011 → resp=1010, err_mask=0001, pass=0.
- Shift-in check: DI forced to X during the shift cycles only; after SHIFT_IN, probe cell contents = pattern 4'b1001 exactly.
- Start while busy: second start pulse in SHIFT_OUT with a different pattern → ignored, single done, result from the first pattern; a new start in the cycle after done is accepted.
- Reset mid SHIFT_OUT: RSTn low for 1 cycle at the 2nd unload cycle → SE=0, busy=0, done never pulses, resp=0; the next full test passes normally.
- Back-to-back: start held high continuously → tests repeat with one IDLE cycle between done and the next busy; every result is correct.
